// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;
  localparam int LINES      = 4;
  localparam int LINE_BYTES = 16;
  localparam int TAG_W      = 26;
  localparam int IDX_W      = 2;
  localparam int LINE_W     = LINE_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_e;
endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: async read of one line, sync word/byte store or line fill.
module dcache_array
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  idx,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [LINE_W-1:0] rd_line,
  input  logic              st_en,
  input  logic              st_byte,
  input  logic [1:0]        st_word,
  input  logic [1:0]        st_lane,
  input  logic [31:0]       st_data,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              clean_en
);
  logic [LINE_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;
  logic [LINE_W-1:0] line_d;

  assign rd_tag   = tag_q[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_line  = data_q[idx];

  // Big-endian lanes: lane 0 is the most significant byte of the word.
  always_comb begin
    line_d = data_q[idx];
    if (fill_en) begin
      line_d = fill_line;
    end else if (st_byte) begin
      line_d[32*int'(st_word) + 8*(3-int'(st_lane)) +: 8] = st_data[7:0];
    end else begin
      line_d[32*int'(st_word) +: 32] = st_data;
    end
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill_en) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (st_en) begin
      dirty_d[idx] = 1'b1;
    end
    if (clean_en) dirty_d[idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en || st_en) data_q[idx] <= line_d;
    if (fill_en)          tag_q[idx]  <= fill_tag;
  end
endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache: zero-wait hits, blocking misses.
module dcache
  import dcache_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         we,
  input  logic         byte_en,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  output logic         dhit,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ack,
  output logic [1:0]   dbg_state,
  output logic [31:0]  dbg_addr,
  output logic         dbg_we,
  output logic         dbg_byte_en,
  output logic [31:0]  dbg_wdata
);
  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        byte_en_q, byte_en_d;
  logic [31:0] wdata_q, wdata_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid, rd_dirty;
  logic [LINE_W-1:0] rd_line;
  logic              is_idle, hit;

  // The array is indexed by the live CPU address in IDLE and by the latched miss otherwise.
  assign is_idle = (state_q == IDLE);
  assign idx     = is_idle ? addr[5:4] : addr_q[5:4];
  assign hit     = req && rd_valid && (rd_tag == addr[31:6]) && is_idle;
  assign dhit    = is_idle && (!req || hit);

  always_comb begin
    rdata = rd_line[31:0];
    case (addr[3:2])
      2'd1:    rdata = rd_line[63:32];
      2'd2:    rdata = rd_line[95:64];
      2'd3:    rdata = rd_line[127:96];
      default: rdata = rd_line[31:0];
    endcase
  end

  dcache_array u_array (
    .clk       (clk),
    .reset     (reset),
    .idx       (idx),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_line   (rd_line),
    .st_en     (hit && we),
    .st_byte   (byte_en),
    .st_word   (addr[3:2]),
    .st_lane   (addr[1:0]),
    .st_data   (wdata),
    .fill_en   ((state_q == REFILL) && mem_ack),
    .fill_tag  (addr_q[31:6]),
    .fill_line (mem_rdata),
    .clean_en  ((state_q == WRITEBACK) && mem_ack)
  );

  // Memory outputs decode from state only, so an async reset drops mem_req at once.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    byte_en_d = byte_en_q;
    wdata_d   = wdata_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          addr_d    = addr;
          we_d      = we;
          byte_en_d = byte_en;
          wdata_d   = wdata;
          state_d   = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {rd_tag, addr_q[5:4], 4'b0000};
        mem_wdata = rd_line;
        if (mem_ack) state_d = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[31:4], 4'b0000};
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      byte_en_q <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      byte_en_q <= byte_en_d;
      wdata_q   <= wdata_d;
    end
  end

  assign dbg_state   = state_q;
  assign dbg_addr    = addr_q;
  assign dbg_we      = we_q;
  assign dbg_byte_en = byte_en_q;
  assign dbg_wdata   = wdata_q;
endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: a vector table of resident-line hits plus miss/write-back/reset sequences.
module tb_dcache;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req = 1'b0, we = 1'b0, byte_en = 1'b0;
  logic [31:0]  addr = '0, wdata = '0;
  logic [31:0]  rdata;
  logic         dhit;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         resp_ack = 1'b0, spur_ack = 1'b0;
  logic [1:0]   dbg_state;
  logic [31:0]  dbg_addr, dbg_wdata;
  logic         dbg_we, dbg_byte_en;

  int checks = 0;
  int failures = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  logic [127:0] mem_store [logic [31:0]];
  logic         xfer_q [$];
  logic [31:0]  last_wb_addr = '0, last_rf_addr = '0;
  logic [127:0] last_wb_data = '0;
  logic [31:0]  exp_q [$];

  assign mem_ack = resp_ack | spur_ack;

  dcache dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .byte_en(byte_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .dhit(dhit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbg_state(dbg_state), .dbg_addr(dbg_addr), .dbg_we(dbg_we),
    .dbg_byte_en(dbg_byte_en), .dbg_wdata(dbg_wdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory responder ----------------
  function automatic logic [127:0] pattern(input logic [31:0] a);
    pattern = {a | 32'hA000_000C, a | 32'hA000_0008, a | 32'hA000_0004, a | 32'hA000_0000};
  endfunction

  // Acks ack_delay cycles after mem_req rises (0 = same cycle).
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      if (wait_cnt == ack_delay) begin
        resp_ack = 1'b1;
        if (mem_we) begin
          mem_store[mem_addr] = mem_wdata;
          last_wb_addr = mem_addr;
          last_wb_data = mem_wdata;
        end else begin
          mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : pattern(mem_addr);
          last_rf_addr = mem_addr;
        end
        xfer_q.push_back(mem_we);
        wait_cnt = 0;
      end else begin
        resp_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      resp_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // ---------------- checking / driver tasks ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; holds the request until dhit, returns at the negedge after the hit.
  task automatic do_access(input logic w, input logic b, input logic [31:0] a,
                           input logic [31:0] d, input int dly,
                           output int stall, output logic [31:0] rd);
    ack_delay = dly;
    req = 1'b1; we = w; byte_en = b; addr = a; wdata = d;
    stall = 0;
    rd = '0;
    #1;
    while (!dhit && stall < 40) begin
      @(negedge clk);
      #1;
      stall++;
    end
    if (!dhit) begin
      failures++;
      $display("FAIL access_timeout: addr %0h got no dhit after %0d cycles", a, stall);
    end
    rd = rdata;
    @(negedge clk);
    req = 1'b0; we = 1'b0; byte_en = 1'b0;
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic        be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_dhit;
    logic        chk_rd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  // ---------------- stimulus ----------------
  initial begin
    int          stall;
    logic [31:0] rd;
    logic [31:0] exp_rd;

    mem_store[32'h40] = 128'h11111111_22222222_33333333_44444444;

    vecs[0]  = '{1, 1, 1, 32'h41, 32'h0000_00AB, 1, 0, 32'h0};
    vecs[1]  = '{1, 0, 0, 32'h40, 32'h0,         1, 1, 32'h44AB_4444};
    vecs[2]  = '{1, 0, 0, 32'h43, 32'h0,         1, 1, 32'h44AB_4444};
    vecs[3]  = '{1, 1, 0, 32'h4A, 32'hDEAD_BEEF, 1, 0, 32'h0};
    vecs[4]  = '{1, 0, 0, 32'h48, 32'h0,         1, 1, 32'hDEAD_BEEF};
    vecs[5]  = '{1, 1, 1, 32'h4F, 32'h1234_56CD, 1, 0, 32'h0};
    vecs[6]  = '{1, 0, 0, 32'h4C, 32'h0,         1, 1, 32'h1111_11CD};
    vecs[7]  = '{1, 1, 1, 32'h4C, 32'h0000_0077, 1, 0, 32'h0};
    vecs[8]  = '{1, 0, 0, 32'h4C, 32'h0,         1, 1, 32'h7711_11CD};
    vecs[9]  = '{0, 0, 0, 32'h44, 32'h0,         1, 1, 32'h3333_3333};
    vecs[10] = '{1, 0, 0, 32'h44, 32'h0,         1, 1, 32'h3333_3333};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_dhit", dhit, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 128'h0);
    check("rst_state", dbg_state, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Cold miss, ack three cycles after mem_req rises
    xfer_q.delete();
    do_access(0, 0, 32'h40, 32'h0, 3, stall, rd);
    check("s1_stall", stall, 5);
    check("s1_rf_addr", last_rf_addr, 32'h40);
    check("s1_xfers", xfer_q.size(), 1);
    if (xfer_q.size() == 1) check("s1_mem_we", xfer_q[0], 1'b0);
    check("s1_rdata", rd, 32'h4444_4444);
    do_access(0, 0, 32'h4C, 32'h0, 3, stall, rd);
    check("s1_next_stall", stall, 0);
    check("s1_next_rdata", rd, 32'h1111_1111);

    // Vector table on the resident line at index 0
    for (int i = 0; i < 11; i++) begin
      req = vecs[i].req; we = vecs[i].we; byte_en = vecs[i].be;
      addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_dhit", i), dhit, vecs[i].exp_dhit);
      check($sformatf("vec%0d_mem_req", i), mem_req, 1'b0);
      if (vecs[i].chk_rd) begin
        exp_q.push_back(vecs[i].exp_rdata);
        exp_rd = exp_q.pop_front();
        check($sformatf("vec%0d_rdata", i), rdata, exp_rd);
      end
      @(negedge clk);
    end
    req = 1'b0; we = 1'b0; byte_en = 1'b0;

    // Conflict miss on a dirty line: write-back then refill
    xfer_q.delete();
    do_access(0, 0, 32'h100, 32'h0, 1, stall, rd);
    check("s3_xfers", xfer_q.size(), 2);
    if (xfer_q.size() == 2) begin
      check("s3_first_is_wb", xfer_q[0], 1'b1);
      check("s3_second_is_rf", xfer_q[1], 1'b0);
    end
    check("s3_wb_addr", last_wb_addr, 32'h40);
    check("s3_wb_word0", last_wb_data[31:0], 32'h44AB_4444);
    check("s3_wb_line", last_wb_data, 128'h771111CD_DEADBEEF_33333333_44AB4444);
    check("s3_rf_addr", last_rf_addr, 32'h100);
    check("s3_stall", stall, 5);
    check("s3_rdata", rd, 32'hA000_0100);

    // Same-cycle ack on a clean victim; the line round-trips through memory
    xfer_q.delete();
    do_access(0, 0, 32'h40, 32'h0, 0, stall, rd);
    check("s4_stall", stall, 2);
    check("s4_xfers", xfer_q.size(), 1);
    check("s4_rf_addr", last_rf_addr, 32'h40);
    check("s4_rdata", rd, 32'h44AB_4444);

    // Stray ack while idle must be ignored
    spur_ack = 1'b1;
    #1;
    check("spur_mem_req", mem_req, 1'b0);
    check("spur_dhit", dhit, 1'b1);
    @(negedge clk);
    spur_ack = 1'b0;
    #1;
    check("spur_state", dbg_state, 2'd0);
    do_access(0, 0, 32'h48, 32'h0, 0, stall, rd);
    check("spur_hit_stall", stall, 0);
    check("spur_hit_rdata", rd, 32'hDEAD_BEEF);

    // Store miss allocates, then a conflicting load writes the merged line back
    do_access(1, 0, 32'hA4, 32'hCAFE_F00D, 0, stall, rd);
    check("sm_stall", stall, 2);
    xfer_q.delete();
    do_access(0, 0, 32'h1A0, 32'h0, 0, stall, rd);
    check("sm_wb_stall", stall, 3);
    check("sm_xfers", xfer_q.size(), 2);
    check("sm_wb_addr", last_wb_addr, 32'hA0);
    check("sm_wb_line", last_wb_data, 128'hA00000AC_A00000A8_CAFEF00D_A00000A0);
    check("sm_rdata", rd, 32'hA000_01A0);

    // Reset in the middle of a refill
    ack_delay = 5;
    req = 1'b1; we = 1'b0; addr = 32'h90;
    @(negedge clk);
    #1;
    check("rr_state_refill", dbg_state, 2'd2);
    check("rr_mem_req_on", mem_req, 1'b1);
    check("rr_mem_addr", mem_addr, 32'h90);
    check("rr_dbg_addr", dbg_addr, 32'h90);
    check("rr_dbg_we", dbg_we, 1'b0);
    reset = 1'b0;
    #1;
    check("rr_mem_req_off", mem_req, 1'b0);
    check("rr_mem_addr_off", mem_addr, 32'h0);
    check("rr_state_idle", dbg_state, 2'd0);
    req = 1'b0;
    #1;
    check("rr_dhit", dhit, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    xfer_q.delete();
    do_access(0, 0, 32'h40, 32'h0, 0, stall, rd);
    check("rr_remiss_stall", stall, 2);
    check("rr_remiss_xfers", xfer_q.size(), 1);
    check("rr_remiss_rdata", rd, 32'h44AB_4444);

    // Idle for ten cycles
    for (int i = 0; i < 10; i++) begin
      addr = 32'h40 + 32'(4 * (i % 4));
      #1;
      check($sformatf("idle%0d_dhit", i), dhit, 1'b1);
      check($sformatf("idle%0d_mem_req", i), mem_req, 1'b0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
